qsys_system_alarm_rtc: RTL and testbench

Avalon-MM real-time-clock and alarm slave fed by the 1 Hz one-second timer's `irq` output. Counts hours, minutes and seconds on each rising edge of `tick_in`. Compares the running time against a programmable alarm with snooze, and raises `alarm_active` for the jukebox player plus `irq` for the CPU. Register-read style matches the other Qsys slaves: 16-bit data, 3-bit word address, registered readdata.

---
 rtl/alarm_rtc_pkg.sv | 26 ++
 rtl/rtc_wrap_counter.sv | 41 ++++
 rtl/qsys_system_alarm_rtc.sv | 174 +++++++++++++++++
 tb/tb_qsys_system_alarm_rtc.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/alarm_rtc_pkg.sv
// Shared constants for the Avalon-MM real-time clock / alarm slave:
// register word addresses, CONTROL/STATUS bit positions and wrap limits.
package alarm_rtc_pkg;

  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_TIME_HM  = 3'd2;
  localparam logic [2:0] ADDR_SECONDS  = 3'd3;
  localparam logic [2:0] ADDR_ALARM_HM = 3'd4;
  localparam logic [2:0] ADDR_SNOOZE   = 3'd5;

  localparam int STAT_PENDING   = 0;
  localparam int STAT_TICK_SEEN = 1;

  localparam int CTRL_RUN      = 0;
  localparam int CTRL_ALARM_EN = 1;
  localparam int CTRL_IRQ_EN   = 2;

  localparam int SEC_MAX = 59;
  localparam int MIN_MAX = 59;
  localparam int HR_MAX  = 23;

  localparam int MS_W = 6;
  localparam int HR_W = 5;

endpackage

// File: rtl/rtc_wrap_counter.sv
// Loadable modulo-(MAX+1) counter; out-of-range load values store 0 and
// carry pulses when an increment wraps MAX back to 0.
module rtc_wrap_counter #(
  parameter int W   = 6,
  parameter int MAX = 59
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         inc,
  output logic [W-1:0] q,
  output logic         carry
);

  localparam logic [W-1:0] MaxVal = W'(MAX);

  logic [W-1:0] count_q, count_d;

  // A load always beats an increment so a register write drops the tick.
  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = (load_val > MaxVal) ? '0 : load_val;
    end else if (inc) begin
      count_d = (count_q == MaxVal) ? '0 : count_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign q     = count_q;
  assign carry = inc & ~load & (count_q == MaxVal);

endmodule

// File: rtl/qsys_system_alarm_rtc.sv
// Avalon-MM RTC/alarm slave: hh:mm:ss counted from the 1 Hz timer irq,
// programmable alarm with snooze, registered 16-bit readdata.
module qsys_system_alarm_rtc
  import alarm_rtc_pkg::*;
#(
  parameter bit TICK_EDGE = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [2:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [15:0] writedata,
  input  logic        tick_in,
  output logic [15:0] readdata,
  output logic        irq,
  output logic        alarm_active
);

  logic wr, wrStatus, wrCtrl, wrTime, wrSec, wrAlarm, wrSnooze, timeWr;
  logic tickEv, step, match, matchRise;
  logic secCarry, minCarry, unusedHrCarry;
  logic [MS_W-1:0] sec, min;
  logic [HR_W-1:0] hr;

  logic              tickD_q, matchD_q, pending_q, tickSeen_q;
  logic              pending_d, tickSeen_d;
  logic [2:0]        ctrl_q, ctrl_d;
  logic [HR_W-1:0]   alarmHr_q, alarmHr_d;
  logic [MS_W-1:0]   alarmMin_q, alarmMin_d, snooze_q, snooze_d;
  logic [15:0]       readdata_q, readdata_d;
  logic [HR_W-1:0]   hrIn;
  logic [MS_W-1:0]   minIn;

  logic [6:0]        snzSum;
  logic [5:0]        snzHrSum;
  logic [MS_W-1:0]   snzMin;
  logic [HR_W-1:0]   snzHr;
  logic              unusedWd;

  assign unusedWd = ^{writedata[15:13], writedata[7:6]};

  assign wr       = chipselect & ~write_n;
  assign wrStatus = wr & (address == ADDR_STATUS);
  assign wrCtrl   = wr & (address == ADDR_CONTROL);
  assign wrTime   = wr & (address == ADDR_TIME_HM);
  assign wrSec    = wr & (address == ADDR_SECONDS);
  assign wrAlarm  = wr & (address == ADDR_ALARM_HM);
  assign wrSnooze = wr & (address == ADDR_SNOOZE);
  assign timeWr   = wrTime | wrSec;

  assign tickEv = TICK_EDGE ? (tick_in & ~tickD_q) : tick_in;
  assign step   = ctrl_q[CTRL_RUN] & tickEv & ~timeWr;

  rtc_wrap_counter #(.W(MS_W), .MAX(SEC_MAX)) u_sec (
    .clk      (clk),
    .reset    (reset),
    .load     (timeWr),
    .load_val (wrTime ? '0 : writedata[5:0]),
    .inc      (step),
    .q        (sec),
    .carry    (secCarry)
  );

  rtc_wrap_counter #(.W(MS_W), .MAX(MIN_MAX)) u_min (
    .clk      (clk),
    .reset    (reset),
    .load     (wrTime),
    .load_val (writedata[5:0]),
    .inc      (secCarry),
    .q        (min),
    .carry    (minCarry)
  );

  rtc_wrap_counter #(.W(HR_W), .MAX(HR_MAX)) u_hr (
    .clk      (clk),
    .reset    (reset),
    .load     (wrTime),
    .load_val (writedata[12:8]),
    .inc      (minCarry),
    .q        (hr),
    .carry    (unusedHrCarry)
  );

  assign match     = ctrl_q[CTRL_ALARM_EN] & (sec == '0) & (hr == alarmHr_q) & (min == alarmMin_q);
  assign matchRise = match & ~matchD_q;

  // Snooze: alarm minutes + up to 63 minutes, carrying at most two hours, wrapping at midnight.
  always_comb begin
    snzSum   = {1'b0, alarmMin_q} + {1'b0, writedata[5:0]};
    snzHrSum = {1'b0, alarmHr_q};
    snzMin   = snzSum[5:0];
    if (snzSum >= 7'd120) begin
      snzMin   = 6'(snzSum - 7'd120);
      snzHrSum = snzHrSum + 6'd2;
    end else if (snzSum >= 7'd60) begin
      snzMin   = 6'(snzSum - 7'd60);
      snzHrSum = snzHrSum + 6'd1;
    end
    snzHr = snzHrSum[4:0];
    if (snzHrSum > 6'(HR_MAX)) begin
      snzHr = 5'(snzHrSum - 6'd24);
    end
  end

  assign hrIn  = (int'(writedata[12:8]) > HR_MAX)  ? '0 : writedata[12:8];
  assign minIn = (int'(writedata[5:0])  > MIN_MAX) ? '0 : writedata[5:0];

  // Set-over-clear for the status bits so a coincident W1C never loses an event.
  always_comb begin
    ctrl_d     = ctrl_q;
    alarmHr_d  = alarmHr_q;
    alarmMin_d = alarmMin_q;
    snooze_d   = snooze_q;
    if (wrCtrl) begin
      ctrl_d = writedata[2:0];
    end
    if (wrAlarm) begin
      alarmHr_d  = hrIn;
      alarmMin_d = minIn;
    end else if (wrSnooze) begin
      alarmHr_d  = snzHr;
      alarmMin_d = snzMin;
      snooze_d   = writedata[5:0];
    end
    pending_d  = matchRise | (pending_q  & ~(wrStatus & writedata[STAT_PENDING]));
    tickSeen_d = tickEv    | (tickSeen_q & ~(wrStatus & writedata[STAT_TICK_SEEN]));
  end

  always_comb begin
    readdata_d = '0;
    case (address)
      ADDR_STATUS: begin
        readdata_d[STAT_PENDING]   = pending_q;
        readdata_d[STAT_TICK_SEEN] = tickSeen_q;
      end
      ADDR_CONTROL:  readdata_d[2:0] = ctrl_q;
      ADDR_TIME_HM:  readdata_d = {3'd0, hr, 2'd0, min};
      ADDR_SECONDS:  readdata_d[5:0] = sec;
      ADDR_ALARM_HM: readdata_d = {3'd0, alarmHr_q, 2'd0, alarmMin_q};
      ADDR_SNOOZE:   readdata_d[5:0] = snooze_q;
      default:       readdata_d = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      tickD_q    <= 1'b0;
      matchD_q   <= 1'b0;
      pending_q  <= 1'b0;
      tickSeen_q <= 1'b0;
      ctrl_q     <= '0;
      alarmHr_q  <= '0;
      alarmMin_q <= '0;
      snooze_q   <= '0;
      readdata_q <= '0;
    end else begin
      tickD_q    <= tick_in;
      matchD_q   <= match;
      pending_q  <= pending_d;
      tickSeen_q <= tickSeen_d;
      ctrl_q     <= ctrl_d;
      alarmHr_q  <= alarmHr_d;
      alarmMin_q <= alarmMin_d;
      snooze_q   <= snooze_d;
      readdata_q <= readdata_d;
    end
  end

  assign readdata     = readdata_q;
  assign irq          = pending_q & ctrl_q[CTRL_IRQ_EN];
  assign alarm_active = pending_q;

endmodule

// File: tb/tb_qsys_system_alarm_rtc.sv
// Bench for the RTC/alarm slave: directed scenarios plus random bus/tick
// traffic, every cycle compared against a seconds-of-day reference model.
module tb_qsys_system_alarm_rtc;

  logic        clk = 1'b0;
  logic        reset;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic        tick_in;
  logic [15:0] readdata;
  logic        irq;
  logic        alarm_active;

  int compared   = 0;
  int mismatched = 0;

  // Reference state: time as seconds of day, alarm as minutes of day.
  int          mTime, mAlarm, mSnooze;
  logic [2:0]  mCtrl;
  bit          mPend, mSeen, mTickPrev, mMatchPrev;
  logic [15:0] mRd;

  always #5 clk = ~clk;

  qsys_system_alarm_rtc #(.TICK_EDGE(1'b1)) dut (
    .clk          (clk),
    .reset        (reset),
    .address      (address),
    .chipselect   (chipselect),
    .write_n      (write_n),
    .writedata    (writedata),
    .tick_in      (tick_in),
    .readdata     (readdata),
    .irq          (irq),
    .alarm_active (alarm_active)
  );

  task automatic checkOutput(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    compared++;
    if (obs !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%04h expected 0x%04h at %0t", tag, obs, exp, $time);
    end
  endtask

  function automatic logic [15:0] hmWord(input int totalMin);
    return 16'(((totalMin / 60) << 8) | (totalMin % 60));
  endfunction

  function automatic logic [15:0] modelRead(input logic [2:0] a);
    case (a)
      3'd0:    return {14'd0, mSeen, mPend};
      3'd1:    return {13'd0, mCtrl};
      3'd2:    return hmWord(mTime / 60);
      3'd3:    return 16'(mTime % 60);
      3'd4:    return hmWord(mAlarm);
      3'd5:    return 16'(mSnooze);
      default: return 16'd0;
    endcase
  endfunction

  // Drive one cycle of inputs, advance the model, then check all outputs after the edge.
  task automatic applyStimulus(input bit rst, input bit cs, input bit wn,
                               input logic [2:0] a, input logic [15:0] wd, input bit tk);
    bit wr, tickEv, matchNow, rise;
    int h, m, s;
    reset = rst; chipselect = cs; write_n = wn; address = a; writedata = wd; tick_in = tk;
    if (rst) begin
      mTime = 0; mAlarm = 0; mSnooze = 0; mCtrl = 3'd0;
      mPend = 0; mSeen = 0; mTickPrev = 0; mMatchPrev = 0; mRd = 16'd0;
    end else begin
      wr       = cs && !wn;
      tickEv   = tk && !mTickPrev;
      matchNow = mCtrl[1] && (mTime % 60 == 0) && (mTime / 60 == mAlarm);
      rise     = matchNow && !mMatchPrev;
      mRd      = modelRead(a);
      if (wr && a == 3'd2) begin
        h = int'(wd[12:8]); m = int'(wd[5:0]);
        if (h >= 24) h = 0;
        if (m >= 60) m = 0;
        mTime = (h * 60 + m) * 60;
      end else if (wr && a == 3'd3) begin
        s = int'(wd[5:0]);
        if (s >= 60) s = 0;
        mTime = mTime - (mTime % 60) + s;
      end else if (mCtrl[0] && tickEv) begin
        mTime = (mTime + 1) % 86400;
      end
      if (wr && a == 3'd4) begin
        h = int'(wd[12:8]); m = int'(wd[5:0]);
        if (h >= 24) h = 0;
        if (m >= 60) m = 0;
        mAlarm = h * 60 + m;
      end
      if (wr && a == 3'd5) begin
        mAlarm  = (mAlarm + int'(wd[5:0])) % 1440;
        mSnooze = int'(wd[5:0]);
      end
      mPend = rise   || (mPend && !(wr && a == 3'd0 && wd[0]));
      mSeen = tickEv || (mSeen && !(wr && a == 3'd0 && wd[1]));
      if (wr && a == 3'd1) mCtrl = wd[2:0];
      mTickPrev  = tk;
      mMatchPrev = matchNow;
    end
    @(posedge clk);
    #1;
    checkOutput("readdata", readdata, mRd);
    checkOutput("irq", {15'd0, irq}, {15'd0, mPend & mCtrl[2]});
    checkOutput("alarm_active", {15'd0, alarm_active}, {15'd0, mPend});
  endtask

  task automatic writeReg(input logic [2:0] a, input logic [15:0] d);
    applyStimulus(1'b0, 1'b1, 1'b0, a, d, 1'b0);
  endtask

  task automatic readExpect(input string tag, input logic [2:0] a, input logic [15:0] exp);
    applyStimulus(1'b0, 1'b1, 1'b1, a, 16'd0, 1'b0);
    checkOutput(tag, readdata, exp);
  endtask

  task automatic tickPulse();
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 1'b0);
  endtask

  initial begin
    int r;
    logic [2:0]  a;
    logic [15:0] wd;
    bit          tk;

    $display("[TB] reset and empty register map");
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 16'd0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 16'd0, 1'b0);
    for (int i = 0; i < 8; i++) readExpect("resetRead", 3'(i), 16'd0);
    checkOutput("resetIrq", {15'd0, irq}, 16'd0);

    $display("[TB] midnight rollover");
    writeReg(3'd2, 16'h173B);
    writeReg(3'd3, 16'd59);
    writeReg(3'd1, 16'd1);
    tickPulse();
    readExpect("rolloverSec", 3'd3, 16'd0);
    readExpect("rolloverHm", 3'd2, 16'd0);

    $display("[TB] alarm fires one cycle after time update");
    writeReg(3'd4, 16'h0705);
    writeReg(3'd1, 16'd7);
    writeReg(3'd2, 16'h0704);
    writeReg(3'd3, 16'd59);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 1'b1);
    checkOutput("irqNotYet", {15'd0, irq}, 16'd0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 1'b0);
    checkOutput("irqFires", {15'd0, irq}, 16'd1);
    writeReg(3'd0, 16'd1);
    checkOutput("irqCleared", {15'd0, irq}, 16'd0);
    for (int i = 0; i < 59; i++) tickPulse();
    checkOutput("noRefire", {15'd0, alarm_active}, 16'd0);

    $display("[TB] snooze across midnight");
    writeReg(3'd4, 16'h1737);
    writeReg(3'd5, 16'd10);
    readExpect("snoozeAlarm", 3'd4, 16'h0005);
    readExpect("snoozeVal", 3'd5, 16'd10);

    $display("[TB] range clamp and held tick");
    writeReg(3'd2, 16'h193D);
    readExpect("clampHm", 3'd2, 16'h0000);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 1'b0);
    readExpect("heldTickSec", 3'd3, 16'd1);

    $display("[TB] write beats tick, set beats clear");
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd2, 16'h0A14, 1'b1);
    readExpect("writeWinsHm", 3'd2, 16'h0A14);
    readExpect("writeWinsSec", 3'd3, 16'd0);
    writeReg(3'd4, 16'h0A15);
    writeReg(3'd3, 16'd59);
    writeReg(3'd0, 16'd3);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0, 16'd0, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0, 16'd1, 1'b0);
    checkOutput("setBeatsClear", {15'd0, alarm_active}, 16'd1);

    $display("[TB] reset mid-count");
    tickPulse();
    tickPulse();
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd0, 16'd0, 1'b0);
    checkOutput("midResetRd", readdata, 16'd0);
    checkOutput("midResetIrq", {15'd0, irq}, 16'd0);
    for (int i = 0; i < 8; i++) readExpect("midResetRead", 3'(i), 16'd0);

    $display("[TB] randomized traffic");
    writeReg(3'd1, 16'd7);
    for (int i = 0; i < 2500; i++) begin
      r  = int'($urandom_range(0, 99));
      a  = 3'($urandom_range(0, 7));
      wd = 16'($urandom);
      tk = ($urandom_range(0, 2) == 0);
      if (r == 0 && $urandom_range(0, 9) == 0)
        applyStimulus(1'b1, 1'b0, 1'b1, a, wd, tk);
      else if (r < 3)
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd4, hmWord((mTime / 60 + 1) % 1440), tk);
      else if (r < 5)
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd3, 16'd58, tk);
      else if (r < 7)
        applyStimulus(1'b0, 1'b1, 1'b0, 3'd1, {13'd0, 3'($urandom) | 3'b001}, tk);
      else if (r < 12)
        applyStimulus(1'b0, 1'b1, 1'b0, a, wd, tk);
      else
        applyStimulus(1'b0, 1'($urandom_range(0, 1)), 1'b1, a, wd, tk);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
